writeback_arbiter: RTL
======================

# writeback_arbiter

Drives the single write port of the integer register file (`a3`/`wd`/`wen`) from two result producers: the single-cycle ALU path and the multi-cycle load unit. Each source has a one-entry holding slot with a valid/ready handshake, and a round-robin arbiter grants one write per cycle. The block also owns a pending-write scoreboard that decode reads to stall on RAW and WAW hazards. It sits between execute/memory and the register file, as the writer-side counterpart of the combinational read ports.

## Interface
- `XLEN`, 32, data width.
- `NREG`, 32, architectural register count; addresses are `$clog2(NREG)` = 5 bits.

- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `issue_valid` in 1: decode issues an instruction that will write `issue_rd`.
- `issue_rd` in 5: destination register of the issued instruction.
- `issue_ready` out 1: issue is allowed; low when `busy[issue_rd]` is set.
- `busy` out NREG: scoreboard; bit r is set while a write to r is pending.
- `alu_valid` in 1, `alu_ready` out 1, `alu_rd` in 5, `alu_data` in XLEN: ALU result channel.
- `mem_valid` in 1, `mem_ready` out 1, `mem_rd` in 5, `mem_data` in XLEN: load result channel.
- `rf_a3` out 5, `rf_wd` out XLEN, `rf_wen` out 1: register file write port. All are registered.

## Operation
- **Handshake.** A transfer happens on a rising edge when `valid && ready`. Sources hold `rd` and `data` stable while `valid` is high and `ready` is low.
- **Slots.** Each source has a one-entry slot (`full`, `rd`, `data`).
  - `x_ready = !full_x || grant_x`. An uncontended source can therefore transfer every cycle.
- **Arbitration (combinational on slot state).**
  - Only one slot full: that slot is granted.
  - Both slots full: the slot not granted last time wins, tracked by a 1-bit `last_grant`.
  - `last_grant` updates only when both slots competed.
- **Grant.** The granted slot loads the output registers on the next edge: `rf_wen <= (rd != 0)`, `rf_a3 <= rd`, `rf_wd <= data`. The slot empties unless it is refilled on the same edge.
- **No grant.** `rf_wen <= 0`. `rf_a3` and `rf_wd` hold their values.
- **rd = 0.** Results are accepted and granted normally but produce no write (`rf_wen` stays 0).
- **Scoreboard.**
  - On `issue_valid && issue_ready && issue_rd != 0`, set `busy[issue_rd]`.
  - On any edge where `rf_wen` is high, clear `busy[rf_a3]`.
  - If a set and a clear target different registers on the same edge, both take effect.
  - A set and a clear cannot target the same register on the same edge, because `issue_ready` is low while that bit is set.
  - `busy[0]` is constant 0.
  - `issue_ready = !busy[issue_rd]`, combinational.
- **Results for non-busy rd.** These are a protocol violation. The write is still performed and `busy` is unchanged.

## Timing
- **Reset values** (asynchronous, `rst_n` low):
  - both slots empty; `busy` = 0; `last_grant` = ALU, so mem wins the first tie;
  - `rf_wen` = 0, `rf_a3` = 0, `rf_wd` = 0;
  - `alu_ready` = `mem_ready` = 1; `issue_ready` = 1.
- **Reset mid-operation** discards the slot contents and all pending busy bits. No write is emitted after reset asserts.
- **Latency.** A result accepted at edge N is in its slot after N. It is granted in cycle N→N+1, and `rf_wen`/`rf_a3`/`rf_wd` are valid during cycle N+1→N+2. The register file commits it at edge N+2, and the busy bit clears at N+2.
- **Worst case under contention.** A slot waits at most one extra cycle.
- **Throughput.** One register-file write per cycle. Each source sustains 1 result per cycle when the other is idle, and 1 per 2 cycles when both stream.
- **Forwarding.** The block has none. Decode stalls on `busy` until the commit edge.

## Structure
- Package `riscv_pkg` holds:
  - `XLEN_C` and the `reg_addr_t` (logic [4:0]) typedef;
  - `wb_src_e` enum {WB_ALU, WB_MEM} for `last_grant`;
  - `wb_entry_t` struct {rd, data}.
- Sub-module `wb_slot`: a one-entry buffer with `in_valid`/`in_ready`, `full`, `entry` and `drain` ports. It is instantiated twice, once per source.
- The arbiter, output registers and scoreboard stay in the top module.

## Test plan
- **Single write.** Reset, then ALU sends rd=5, data=0xDEADBEEF → `rf_wen` high for exactly one cycle, two cycles after acceptance, with `rf_a3`=5 and `rf_wd`=0xDEADBEEF.
- **Contention.** Both sources are valid on the same cycle with mem rd=3, data=0x11 and ALU rd=4, data=0x22 → mem writes first, ALU on the next cycle. In a repeated contention, ALU wins first (round-robin).
- **Scoreboard.** Issue rd=7 → `busy[7]`=1 and `issue_ready` is low for rd=7 but high for rd=8. A mem result to rd=7 clears `busy[7]` on its commit edge.
- **Register x0.** A result to rd=0 → accepted, `rf_wen` stays 0. Issuing rd=0 → `busy` stays 0.
- **Back-pressure.** ALU streams 4 results back-to-back while mem is idle → `alu_ready` stays 1 and there are 4 consecutive `rf_wen` pulses. With mem streaming at the same time, ready drops and the writes alternate.
- **Reset mid-operation.** Assert `rst_n` low while both slots are full and `busy[9]`=1 → `rf_wen` falls to 0 immediately, `busy`=0, and no stale write appears after release.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared types for the integer writeback path.
//   XLEN_C     : datapath width
//   reg_addr_t : architectural register address
//   wb_src_e   : result producer identity (used for round-robin history)
//   wb_entry_t : one pending register-file write {rd, data}
package riscv_pkg;

  localparam int unsigned XLEN_C = 32;

  typedef logic [4:0] reg_addr_t;

  typedef enum logic {
    WB_ALU = 1'b0,
    WB_MEM = 1'b1
  } wb_src_e;

  typedef struct packed {
    reg_addr_t         rd;
    logic [XLEN_C-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_slot.sv
// One-entry result holding slot with valid/ready input handshake.
//   in_valid/in_ready/in_entry : producer side; transfer on valid && ready
//   full/entry                 : slot contents presented to the arbiter
//   drain                      : slot is granted this cycle and empties
//                                unless refilled on the same edge
module wb_slot
  import riscv_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      in_valid,
  output logic      in_ready,
  input  wb_entry_t in_entry,
  output logic      full,
  output wb_entry_t entry,
  input  logic      drain
);

  logic      full_q, full_d;
  wb_entry_t entry_q, entry_d;

  // A draining slot can accept a new entry on the same edge.
  assign in_ready = !full_q || drain;
  assign full     = full_q;
  assign entry    = entry_q;

  always_comb begin
    full_d  = full_q;
    entry_d = entry_q;
    if (drain) begin
      full_d = 1'b0;
    end
    if (in_valid && in_ready) begin
      full_d  = 1'b1;
      entry_d = in_entry;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q  <= 1'b0;
      entry_q <= '0;
    end else begin
      full_q  <= full_d;
      entry_q <= entry_d;
    end
  end

endmodule

// File: rtl/writeback_arbiter.sv
// Register-file write port arbiter with pending-write scoreboard.
//   issue_valid/issue_rd/issue_ready : decode issue; stalls while rd is busy
//   busy                             : bit r set while a write to r is pending
//   alu_* / mem_*                    : result channels (valid/ready handshake)
//   rf_a3/rf_wd/rf_wen               : registered register-file write port
// Both sources buffer into a one-entry slot; a round-robin arbiter grants one
// slot per cycle and the granted entry is registered onto the write port.
module writeback_arbiter
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NREG = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    issue_valid,
  input  logic [$clog2(NREG)-1:0] issue_rd,
  output logic                    issue_ready,
  output logic [NREG-1:0]         busy,
  input  logic                    alu_valid,
  output logic                    alu_ready,
  input  logic [$clog2(NREG)-1:0] alu_rd,
  input  logic [XLEN-1:0]         alu_data,
  input  logic                    mem_valid,
  output logic                    mem_ready,
  input  logic [$clog2(NREG)-1:0] mem_rd,
  input  logic [XLEN-1:0]         mem_data,
  output logic [$clog2(NREG)-1:0] rf_a3,
  output logic [XLEN-1:0]         rf_wd,
  output logic                    rf_wen
);

  localparam int unsigned AW = $clog2(NREG);

  logic      alu_full, mem_full;
  wb_entry_t alu_entry, mem_entry;
  logic      grant_alu, grant_mem;
  wb_entry_t sel_entry;

  wb_src_e           last_grant_q, last_grant_d;
  logic              rf_wen_q, rf_wen_d;
  logic [AW-1:0]     rf_a3_q, rf_a3_d;
  logic [XLEN-1:0]   rf_wd_q, rf_wd_d;
  logic [NREG-1:0]   busy_q, busy_d;

  wb_slot u_alu_slot (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (alu_valid),
    .in_ready (alu_ready),
    .in_entry ('{rd: alu_rd, data: alu_data}),
    .full     (alu_full),
    .entry    (alu_entry),
    .drain    (grant_alu)
  );

  wb_slot u_mem_slot (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (mem_valid),
    .in_ready (mem_ready),
    .in_entry ('{rd: mem_rd, data: mem_data}),
    .full     (mem_full),
    .entry    (mem_entry),
    .drain    (grant_mem)
  );

  // On a tie the source that did not win last time is granted.
  assign grant_alu = alu_full && (!mem_full || (last_grant_q == WB_MEM));
  assign grant_mem = mem_full && (!alu_full || (last_grant_q == WB_ALU));
  assign sel_entry = grant_mem ? mem_entry : alu_entry;

  assign issue_ready = !busy_q[issue_rd];
  assign busy        = busy_q;
  assign rf_wen      = rf_wen_q;
  assign rf_a3       = rf_a3_q;
  assign rf_wd       = rf_wd_q;

  always_comb begin
    last_grant_d = last_grant_q;
    rf_wen_d     = 1'b0;
    rf_a3_d      = rf_a3_q;
    rf_wd_d      = rf_wd_q;
    busy_d       = busy_q;

    if (alu_full && mem_full) begin
      last_grant_d = grant_mem ? WB_MEM : WB_ALU;
    end

    if (grant_alu || grant_mem) begin
      rf_wen_d = (sel_entry.rd != '0);
      rf_a3_d  = sel_entry.rd;
      rf_wd_d  = sel_entry.data;
    end

    // Clear the committing register, then set the newly issued one; they
    // never collide because issue_ready is low for a busy register.
    if (rf_wen_q) begin
      busy_d[rf_a3_q] = 1'b0;
    end
    if (issue_valid && issue_ready && (issue_rd != '0)) begin
      busy_d[issue_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= WB_ALU;
      rf_wen_q     <= 1'b0;
      rf_a3_q      <= '0;
      rf_wd_q      <= '0;
      busy_q       <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      rf_wen_q     <= rf_wen_d;
      rf_a3_q      <= rf_a3_d;
      rf_wd_q      <= rf_wd_d;
      busy_q       <= busy_d;
    end
  end

endmodule
